// File: rtl/bsearch_ctrl.sv
// bsearch_ctrl: control FSM for a binary-search engine over a synchronous memory.
// The external datapath holds the search bounds, the data register and the match flag;
// this block sequences it through init, memory wait, load and compare, and reports results.
// Ports:
//   clk, clr                 clock, synchronous active-high reset
//   start, key               search request (sampled only in IDLE) and search key
//   busy, done               search in progress, one-cycle completion pulse
//   hit, index, probes       result of the last completed search
//   dp_clr_n, dp_A           datapath init (active-low) and latched key
//   dp_load, dp_mv_addr      datapath data-register load and compare/step strobes
//   dp_found, dp_L           datapath match flag and match address
module bsearch_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned MAX_PROBES = 6,
  parameter int unsigned MEM_LAT    = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] key,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic [ADDR_W-1:0] index,
  output logic [2:0]        probes,
  output logic              dp_clr_n,
  output logic [DATA_W-1:0] dp_A,
  output logic              dp_load,
  output logic              dp_mv_addr,
  input  logic              dp_found,
  input  logic [ADDR_W-1:0] dp_L
);

  localparam int unsigned PROBE_W = 3;
  localparam int unsigned WAIT_W  = 2;
  localparam logic [WAIT_W-1:0]  WAIT_LAST   = WAIT_W'(MEM_LAT - 1);
  localparam logic [PROBE_W-1:0] PROBE_LIMIT = PROBE_W'(MAX_PROBES);
  localparam logic [PROBE_W-1:0] PROBE_SAT   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT, S_LOAD, S_CMP, S_CHK, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0]  key_q, key_d;
  logic [PROBE_W-1:0] probe_cnt_q, probe_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               hit_q, hit_d;
  logic [ADDR_W-1:0]  index_q, index_d;
  logic [PROBE_W-1:0] probes_q, probes_d;
  logic               dp_clr_n_q, dp_clr_n_d;
  logic               dp_load_q, dp_load_d;
  logic               dp_mv_addr_q, dp_mv_addr_d;

  // State register
  always_ff @(posedge clk) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_INIT;
      S_INIT: state_d = S_WAIT;
      S_WAIT: if (wait_cnt_q == WAIT_LAST) state_d = S_LOAD;
      S_LOAD: state_d = S_CMP;
      S_CMP:  state_d = S_CHK;
      // A match on the final allowed probe still reports a hit
      S_CHK:  if (dp_found || (probe_cnt_q == PROBE_LIMIT)) state_d = S_DONE;
              else                                          state_d = S_WAIT;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and counter next values; strobes decode the upcoming state so they register cleanly
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    dp_clr_n_d   = (state_d != S_INIT);
    dp_load_d    = (state_d == S_LOAD);
    dp_mv_addr_d = (state_d == S_CMP);
    key_d        = key_q;
    probe_cnt_d  = probe_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    hit_d        = hit_q;
    index_d      = index_q;
    probes_d     = probes_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d       = key;
          probe_cnt_d = '0;
        end
      end
      S_INIT: wait_cnt_d = '0;
      S_WAIT: wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      S_CMP: begin
        if (probe_cnt_q != PROBE_SAT) probe_cnt_d = probe_cnt_q + PROBE_W'(1);
      end
      S_CHK: begin
        wait_cnt_d = '0;
        if (state_d == S_DONE) begin
          hit_d    = dp_found;
          index_d  = dp_found ? dp_L : '0;
          probes_d = probe_cnt_q;
        end
      end
      default: ;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (clr) begin
      key_q        <= '0;
      probe_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hit_q        <= 1'b0;
      index_q      <= '0;
      probes_q     <= '0;
      dp_clr_n_q   <= 1'b1;
      dp_load_q    <= 1'b0;
      dp_mv_addr_q <= 1'b0;
    end else begin
      key_q        <= key_d;
      probe_cnt_q  <= probe_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      hit_q        <= hit_d;
      index_q      <= index_d;
      probes_q     <= probes_d;
      dp_clr_n_q   <= dp_clr_n_d;
      dp_load_q    <= dp_load_d;
      dp_mv_addr_q <= dp_mv_addr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign hit        = hit_q;
  assign index      = index_q;
  assign probes     = probes_q;
  assign dp_clr_n   = dp_clr_n_q;
  assign dp_A       = key_q;
  assign dp_load    = dp_load_q;
  assign dp_mv_addr = dp_mv_addr_q;

endmodule

// File: tb/tb_bsearch_ctrl.sv
// Bench for bsearch_ctrl: two instances (MEM_LAT=1 and MEM_LAT=3), each driving a
// binary-search datapath over mem[i]=2*i, checked every cycle against a timing/result model.
module tb_bsearch_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       start_s    [2];
  logic [7:0] key_s      [2];
  logic       busy_w     [2];
  logic       done_w     [2];
  logic       hit_w      [2];
  logic [4:0] index_w    [2];
  logic [2:0] probes_w   [2];
  logic       dp_clr_n_w [2];
  logic [7:0] dp_a_w     [2];
  logic       dp_load_w  [2];
  logic       dp_mv_w    [2];
  logic       dp_found_w [2];
  logic [4:0] dp_l_w     [2];

  int cmp_n = 0;
  int err_n = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    logic [4:0] lo_r, hi_r, l_r, mid;
    logic [5:0] sum;
    logic       found_r;
    logic [7:0] dreg;
    logic [7:0] pipe [3];

    assign sum  = {1'b0, lo_r} + {1'b0, hi_r} + 6'd1;
    assign mid  = sum[5:1];
    assign dp_found_w[g] = found_r;
    assign dp_l_w[g]     = l_r;

    bsearch_ctrl #(.DATA_W(8), .ADDR_W(5), .MAX_PROBES(6), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .clr(clr), .start(start_s[g]), .key(key_s[g]),
      .busy(busy_w[g]), .done(done_w[g]), .hit(hit_w[g]), .index(index_w[g]),
      .probes(probes_w[g]), .dp_clr_n(dp_clr_n_w[g]), .dp_A(dp_a_w[g]),
      .dp_load(dp_load_w[g]), .dp_mv_addr(dp_mv_w[g]),
      .dp_found(dp_found_w[g]), .dp_L(dp_l_w[g])
    );

    // Datapath: memory read pipeline plus bound registers stepped on each compare
    always_ff @(posedge clk) begin
      pipe[0] <= {2'b00, mid, 1'b0};
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      if (!dp_clr_n_w[g]) begin
        lo_r <= '0; hi_r <= 5'd31; found_r <= 1'b0; l_r <= '0;
      end else if (dp_load_w[g]) begin
        dreg <= pipe[LAT-1];
      end else if (dp_mv_w[g]) begin
        if (dreg == dp_a_w[g]) begin
          found_r <= 1'b1; l_r <= mid;
        end else if (dreg < dp_a_w[g]) lo_r <= mid + 5'd1;
        else                           hi_r <= mid - 5'd1;
      end
    end
  end

  task automatic chk(input string name, input int inst, input int act_v, input int exp_v);
    cmp_n++;
    if (act_v !== exp_v) begin
      err_n++;
      $display("FAIL %s[%0d]: got %0d, want %0d", name, inst, act_v, exp_v);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Plain binary search over mem[i]=2*i, 32 words, mid rounded up, 6 probes max
  function automatic void bsearch(input int k, output int h, output int idx, output int np);
    int lo, hi, mid;
    lo = 0; hi = 31; np = 0; h = 0; idx = 0;
    while (np < 6) begin
      mid = (lo + hi + 1) / 2;
      np++;
      if (2 * mid == k) begin h = 1; idx = mid; return; end
      if (2 * mid < k) lo = mid + 1;
      else             hi = mid - 1;
    end
  endfunction

  function automatic int strobe_at(input int t, input int first, input int per, input int np);
    if (t < first) return 0;
    return (((t - first) % per) == 0 && ((t - first) / per) < np) ? 1 : 0;
  endfunction

  // Model: t = cycles since the accepting edge (0 = idle), T = cycle holding done
  int t_m [2], T_m [2], np_m [2], ph_m [2], pi_m [2];
  int eh_m [2], ei_m [2], ep_m [2], ea_m [2];
  bit model_ok = 0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        t_m[i] = 0; T_m[i] = 0; np_m[i] = 0;
        eh_m[i] = 0; ei_m[i] = 0; ep_m[i] = 0; ea_m[i] = 0;
        model_ok = 1;
      end else if (t_m[i] == 0) begin
        if (start_s[i]) begin
          ea_m[i] = int'(key_s[i]);
          bsearch(int'(key_s[i]), ph_m[i], pi_m[i], np_m[i]);
          T_m[i] = 5 + lat_of(i) + (np_m[i] - 1) * (lat_of(i) + 3);
          t_m[i] = 1;
        end
      end else if (t_m[i] == T_m[i]) begin
        t_m[i] = 0;
      end else begin
        t_m[i]++;
        if (t_m[i] == T_m[i]) begin
          eh_m[i] = ph_m[i]; ei_m[i] = ph_m[i] != 0 ? pi_m[i] : 0; ep_m[i] = np_m[i];
        end
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < 2; i++) begin
        int t, L, P;
        t = t_m[i]; L = lat_of(i); P = L + 3;
        chk("busy",       i, int'(busy_w[i]),     (t != 0) ? 1 : 0);
        chk("done",       i, int'(done_w[i]),     (t != 0 && t == T_m[i]) ? 1 : 0);
        chk("dp_clr_n",   i, int'(dp_clr_n_w[i]), (t != 1) ? 1 : 0);
        chk("dp_load",    i, int'(dp_load_w[i]),  (t != 0) ? strobe_at(t, 2 + L, P, np_m[i]) : 0);
        chk("dp_mv_addr", i, int'(dp_mv_w[i]),    (t != 0) ? strobe_at(t, 3 + L, P, np_m[i]) : 0);
        chk("hit",        i, int'(hit_w[i]),      eh_m[i]);
        chk("index",      i, int'(index_w[i]),    ei_m[i]);
        chk("probes",     i, int'(probes_w[i]),   ep_m[i]);
        chk("dp_A",       i, int'(dp_a_w[i]),     ea_m[i]);
      end
    end
  end

  task automatic launch(input int i, input logic [7:0] k);
    @(negedge clk);
    start_s[i] = 1'b1; key_s[i] = k;
    @(posedge clk);
  endtask

  // Follow a search from just after its accepting edge; compare hand-computed results
  task automatic watch(input int i, input bit hold, input int chg_c, input logic [7:0] chg_k,
                       input int ec, input int eh, input int ei, input int ep,
                       input int emv, input bit gap);
    int mv, clrn_c, load_c;
    bit seen;
    mv = 0; clrn_c = 0; load_c = 0; seen = 0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) start_s[i] = 1'b0;
      if (c == chg_c) key_s[i] = chg_k;
      if (dp_mv_w[i]) mv++;
      if (!dp_clr_n_w[i]) clrn_c = c;
      if (dp_load_w[i] && load_c == 0) load_c = c;
      if (done_w[i]) begin
        seen = 1;
        chk("done_cycle", i, c, ec);
        chk("res_hit",    i, int'(hit_w[i]), eh);
        chk("res_index",  i, int'(index_w[i]), ei);
        chk("res_probes", i, int'(probes_w[i]), ep);
        if (emv >= 0) chk("mv_pulses", i, mv, emv);
        if (gap) chk("load_after_init", i, load_c - (clrn_c + 1), 3);
      end
    end
    if (!seen) begin
      cmp_n++; err_n++;
      $display("FAIL done_timeout[%0d]: got no done, want done within 100 cycles", i);
    end
  endtask

  initial begin
    int n;
    clr = 1'b1;
    for (int i = 0; i < 2; i++) begin start_s[i] = 1'b0; key_s[i] = 8'd0; end
    repeat (2) @(negedge clk);
    chk("rst_busy", 0, int'(busy_w[0]), 0);
    chk("rst_dp_clr_n", 0, int'(dp_clr_n_w[0]), 1);
    clr = 1'b0;

    // Instance 0, MEM_LAT=1
    launch(0, 8'd32); watch(0, 0, 0, 8'd0, 6, 1, 16, 1, 1, 0);
    launch(0, 8'd38); watch(0, 0, 0, 8'd0, 22, 1, 19, 5, 5, 0);
    launch(0, 8'd7);  watch(0, 0, 0, 8'd0, 26, 0, 0, 6, 6, 0);
    launch(0, 8'd62); watch(0, 0, 0, 8'd0, 22, 1, 31, 5, 5, 0);
    launch(0, 8'd0);  watch(0, 0, 0, 8'd0, 26, 1, 0, 6, 6, 0);

    // start held through the search with a key change; next search only after an IDLE cycle
    launch(0, 8'd38); watch(0, 1, 3, 8'd7, 22, 1, 19, 5, 5, 0);
    @(negedge clk);
    chk("idle_gap_busy", 0, int'(busy_w[0]), 0);
    @(posedge clk);
    watch(0, 0, 0, 8'd0, 26, 0, 0, 6, 6, 0);
    chk("held_key", 0, int'(dp_a_w[0]), 7);

    // clr during the third compare, with start raised at the same edge
    launch(0, 8'd38);
    n = 0;
    for (int c = 0; c < 100 && n < 3; c++) begin
      @(negedge clk);
      start_s[0] = 1'b0;
      if (dp_mv_w[0]) n++;
    end
    if (n < 3) begin
      cmp_n++; err_n++;
      $display("FAIL third_cmp_timeout[0]: got %0d compares, want 3", n);
    end
    clr = 1'b1; start_s[0] = 1'b1; key_s[0] = 8'd32;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_busy", 0, int'(busy_w[0]), 0);
    chk("clr_done", 0, int'(done_w[0]), 0);
    chk("clr_hit", 0, int'(hit_w[0]), 0);
    chk("clr_index", 0, int'(index_w[0]), 0);
    chk("clr_probes", 0, int'(probes_w[0]), 0);
    chk("clr_dp_A", 0, int'(dp_a_w[0]), 0);
    chk("clr_dp_clr_n", 0, int'(dp_clr_n_w[0]), 1);
    chk("clr_dp_load", 0, int'(dp_load_w[0]), 0);
    chk("clr_dp_mv_addr", 0, int'(dp_mv_w[0]), 0);
    @(posedge clk);
    watch(0, 0, 0, 8'd0, 6, 1, 16, 1, 1, 0);

    // Instance 1, MEM_LAT=3
    launch(1, 8'd32); watch(1, 0, 0, 8'd0, 8, 1, 16, 1, 1, 1);
    launch(1, 8'd38); watch(1, 0, 0, 8'd0, 32, 1, 19, 5, 5, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
